// File: rtl/gpio_in_cond.sv
// rtl/gpio_in_cond.sv - GPIO input synchroniser, per-bit debounce, edge detect and sticky interrupt pending
module gpio_in_cond #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT_W    = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [WIDTH-1:0]    pad_i,
  input  logic [WIDTH-1:0]    db_en_i,
  input  logic [DB_CNT_W-1:0] db_limit_i,
  input  logic [WIDTH-1:0]    irq_rise_i,
  input  logic [WIDTH-1:0]    irq_fall_i,
  input  logic [WIDTH-1:0]    irq_en_i,
  input  logic [WIDTH-1:0]    irq_clr_i,
  output logic [WIDTH-1:0]    in_o,
  output logic [WIDTH-1:0]    rise_o,
  output logic [WIDTH-1:0]    fall_o,
  output logic [WIDTH-1:0]    irq_pend_o,
  output logic                irq_o
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
  logic [WIDTH-1:0][DB_CNT_W-1:0]    cnt_q;
  logic [WIDTH-1:0]                  sync_q;
  logic [WIDTH-1:0]                  in_q;
  logic [WIDTH-1:0]                  in_d;
  logic [WIDTH-1:0]                  pend_q;
  logic [WIDTH-1:0]                  rise;
  logic [WIDTH-1:0]                  fall;

  // Stage 0 samples the asynchronous pads; only the last stage is consumed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pad_i};
    end
  end

  assign sync_q = sync_r[SYNC_STAGES-1];

  // A new value is accepted after db_limit_i+1 consecutive mismatch cycles;
  // any match restarts the count, and the >= test keeps cnt from wrapping
  // when the limit is lowered mid-count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!db_en_i[i]) begin
          in_q[i]  <= sync_q[i];
          cnt_q[i] <= '0;
        end else if (sync_q[i] == in_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] >= db_limit_i) begin
          in_q[i]  <= sync_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign rise = in_q & ~in_d;
  assign fall = ~in_q & in_d;

  // Set terms are OR-ed after the clear so a new edge beats a simultaneous W1C.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_d   <= '0;
      pend_q <= '0;
    end else begin
      in_d   <= in_q;
      pend_q <= (pend_q & ~irq_clr_i) | (rise & irq_rise_i) | (fall & irq_fall_i);
    end
  end

  assign in_o       = in_q;
  assign rise_o     = rise;
  assign fall_o     = fall;
  assign irq_pend_o = pend_q;
  assign irq_o      = |(pend_q & irq_en_i);

endmodule

// File: tb/tb_gpio_in_cond.sv
// tb/tb_gpio_in_cond.sv - directed scoreboard bench for gpio_in_cond
module tb_gpio_in_cond;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic [W-1:0] pad_i, db_en_i, irq_rise_i, irq_fall_i, irq_en_i, irq_clr_i;
  logic [7:0]   db_limit_i;
  logic [W-1:0] in_o, rise_o, fall_o, irq_pend_o;
  logic         irq_o;

  gpio_in_cond #(.WIDTH(W), .SYNC_STAGES(2), .DB_CNT_W(8)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .pad_i      (pad_i),
    .db_en_i    (db_en_i),
    .db_limit_i (db_limit_i),
    .irq_rise_i (irq_rise_i),
    .irq_fall_i (irq_fall_i),
    .irq_en_i   (irq_en_i),
    .irq_clr_i  (irq_clr_i),
    .in_o       (in_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .irq_pend_o (irq_pend_o),
    .irq_o      (irq_o)
  );

  always #5 clk = ~clk;

  localparam int K_IN = 0, K_RISE = 1, K_FALL = 2, K_PEND = 3, K_IRQ = 4;

  typedef struct {
    string       tag;
    int          due;
    int          kind;
    logic [31:0] mask;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [31:0] sig(int k);
    case (k)
      K_IN:    return in_o;
      K_RISE:  return rise_o;
      K_FALL:  return fall_o;
      K_PEND:  return irq_pend_o;
      default: return {31'b0, irq_o};
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(string tag, int dly, int kind, logic [31:0] mask, logic [31:0] val);
    exp_t e;
    e.tag  = tag;
    e.due  = cyc + dly;
    e.kind = kind;
    e.mask = mask;
    e.val  = val & mask;
    sb.push_back(e);
  endtask

  task automatic step(int n = 1);
    for (int s = 0; s < n; s++) begin
      @(posedge clk);
      cyc++;
      #1;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          chk(sb[i].tag, sig(sb[i].kind) & sb[i].mask, sb[i].val);
          sb.delete(i);
        end
      end
    end
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_in"},   in_o,       32'h0);
    chk({tag, "_rise"}, rise_o,     32'h0);
    chk({tag, "_fall"}, fall_o,     32'h0);
    chk({tag, "_pend"}, irq_pend_o, 32'h0);
    chk({tag, "_irq"},  {31'b0, irq_o}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni     = 1'b0;
    pad_i      = '0;
    db_en_i    = '0;
    db_limit_i = 8'd4;
    irq_rise_i = '0;
    irq_fall_i = '0;
    irq_en_i   = '0;
    irq_clr_i  = '0;
    #2;
    chk_all_zero("rst_during");
    step();
    rst_ni = 1'b1;
    step();
    chk_all_zero("rst_after");
    step(2);

    // Bypass path, bit 0
    irq_rise_i[0] = 1'b1;
    irq_en_i[0]   = 1'b1;
    pad_i[0]      = 1'b1;
    push("byp_in_early",  2, K_IN,   32'h1, 32'h0);
    push("byp_in",        3, K_IN,   32'h1, 32'h1);
    push("byp_rise",      3, K_RISE, 32'h1, 32'h1);
    push("byp_rise_end",  4, K_RISE, 32'h1, 32'h0);
    push("byp_pend_pre",  3, K_PEND, 32'h1, 32'h0);
    push("byp_pend",      4, K_PEND, 32'h1, 32'h1);
    push("byp_irq_pre",   3, K_IRQ,  32'h1, 32'h0);
    push("byp_irq",       4, K_IRQ,  32'h1, 32'h1);
    step(6);
    irq_clr_i[0] = 1'b1;
    push("byp_clr_pend", 1, K_PEND, 32'h1, 32'h0);
    push("byp_clr_irq",  1, K_IRQ,  32'h1, 32'h0);
    step();
    irq_clr_i = '0;
    step();

    // Debounce bit 3, limit 4: short glitch rejected
    db_en_i[3] = 1'b1;
    pad_i[3]   = 1'b1;
    push("db_short_in3",   3, K_IN,   32'h8, 32'h0);
    push("db_short_in5",   5, K_IN,   32'h8, 32'h0);
    push("db_short_in7",   7, K_IN,   32'h8, 32'h0);
    push("db_short_rise4", 4, K_RISE, 32'h8, 32'h0);
    push("db_short_rise6", 6, K_RISE, 32'h8, 32'h0);
    push("db_short_fall8", 8, K_FALL, 32'h8, 32'h0);
    step(3);
    pad_i[3] = 1'b0;
    step(10);

    // Debounce bit 3: 5-cycle pulse accepted 7 edges after each pad edge
    pad_i[3] = 1'b1;
    push("db_long_in6",    6,  K_IN,   32'h8, 32'h0);
    push("db_long_in7",    7,  K_IN,   32'h8, 32'h8);
    push("db_long_rise7",  7,  K_RISE, 32'h8, 32'h8);
    push("db_long_rise8",  8,  K_RISE, 32'h8, 32'h0);
    push("db_long_in11",   11, K_IN,   32'h8, 32'h8);
    push("db_long_in12",   12, K_IN,   32'h8, 32'h0);
    push("db_long_fall12", 12, K_FALL, 32'h8, 32'h8);
    push("db_long_fall13", 13, K_FALL, 32'h8, 32'h0);
    step(5);
    pad_i[3] = 1'b0;
    step(10);
    db_en_i[3] = 1'b0;

    // Edge selection, bit 5: fall only, masked from irq_o
    irq_fall_i[5] = 1'b1;
    pad_i[5]      = 1'b1;
    push("sel_rise5",     3, K_RISE, 32'h20, 32'h20);
    push("sel_norise_p4", 4, K_PEND, 32'h20, 32'h0);
    push("sel_norise_p5", 5, K_PEND, 32'h20, 32'h0);
    step(6);
    pad_i[5] = 1'b0;
    push("sel_fall5",  3, K_FALL, 32'h20, 32'h20);
    push("sel_pend5",  4, K_PEND, 32'h20, 32'h20);
    push("sel_irq_m",  4, K_IRQ,  32'h1,  32'h0);
    step(4);
    irq_en_i[5] = 1'b1;
    #1;
    chk("sel_irq_en_comb", {31'b0, irq_o}, 32'h1);
    irq_en_i[5] = 1'b0;
    #1;
    chk("sel_irq_dis_comb", {31'b0, irq_o}, 32'h0);
    irq_clr_i[5] = 1'b1;
    push("sel_clr5", 1, K_PEND, 32'h20, 32'h0);
    step();
    irq_clr_i = '0;

    // Clear colliding with a set, bit 7
    irq_rise_i[7] = 1'b1;
    irq_en_i[7]   = 1'b1;
    pad_i[7]      = 1'b1;
    push("col_rise7", 3, K_RISE, 32'h80, 32'h80);
    step(3);
    irq_clr_i[7] = 1'b1;
    push("col_pend7", 1, K_PEND, 32'h80, 32'h80);
    push("col_irq",   1, K_IRQ,  32'h1,  32'h1);
    step();
    irq_clr_i = '0;
    step(2);
    irq_clr_i[7] = 1'b1;
    push("clr_pend7", 1, K_PEND, 32'h80, 32'h0);
    push("clr_irq",   1, K_IRQ,  32'h1,  32'h0);
    step();
    irq_clr_i = '0;

    // All-bits stress
    pad_i      = '0;
    irq_rise_i = '0;
    irq_fall_i = '0;
    step(5);
    irq_clr_i = '1;
    step();
    irq_clr_i = '0;
    chk("str_pend_clear", irq_pend_o, 32'h0);
    irq_rise_i = 32'hA5C3_0F96;
    pad_i      = '1;
    push("str_rise_pre", 2, K_RISE, 32'hFFFF_FFFF, 32'h0);
    push("str_in",       3, K_IN,   32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push("str_rise",     3, K_RISE, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push("str_rise_end", 4, K_RISE, 32'hFFFF_FFFF, 32'h0);
    push("str_pend",     4, K_PEND, 32'hFFFF_FFFF, 32'hA5C3_0F96);
    step(6);

    // Reset mid-debounce with every pending bit set
    irq_rise_i = '1;
    irq_fall_i = '1;
    irq_en_i   = '1;
    pad_i      = '0;
    push("mid_fall", 3, K_FALL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push("mid_pend", 4, K_PEND, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step(4);
    db_en_i[3] = 1'b1;
    pad_i[3]   = 1'b1;
    step(4);
    chk("mid_pend_hold", irq_pend_o, 32'hFFFF_FFFF);
    chk("mid_irq_hold",  {31'b0, irq_o}, 32'h1);
    chk("mid_in3_hold",  in_o & 32'h8, 32'h0);
    rst_ni = 1'b0;
    #1;
    chk_all_zero("rst_async");
    pad_i   = 32'h0000_0001;
    db_en_i = '0;
    step();
    rst_ni = 1'b1;
    for (int d = 1; d <= 6; d++) begin
      push("post_rise", d, K_RISE, 32'hFFFF_FFFF, (d == 3) ? 32'h1 : 32'h0);
      push("post_fall", d, K_FALL, 32'hFFFF_FFFF, 32'h0);
    end
    push("post_in",   3, K_IN,   32'hFFFF_FFFF, 32'h1);
    push("post_pend", 4, K_PEND, 32'hFFFF_FFFF, 32'h1);
    step(7);

    chk("sb_drained", sb.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
